// File: rtl/sha256_arb_pkg.sv
// Shared types and constants for the SHA-256 core memory arbiter.
package sha256_arb_pkg;

  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 32;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWN      = 2'd1,
    ST_HANDOVER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sha256_rr_picker.sv
// Combinational round-robin picker: first requester found starting after last_owner.
module sha256_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] idx_s;

  // Scan from lowest to highest priority so the nearest requester after last_owner wins.
  always_comb begin
    valid  = 1'b0;
    winner = {IDX_W{1'b0}};
    idx_s  = {IDX_W{1'b0}};
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx_s = IDX_W'((int'(last_owner) + i) % NUM_REQ);
      if (req[idx_s]) begin
        valid  = 1'b1;
        winner = idx_s;
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter letting NUM_REQ SHA cores share one memory port, with burst-limited ownership.
module sha256_mem_arbiter
  import sha256_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         acc,
  input  logic [NUM_REQ-1:0]         we_in,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr_in,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_write_data,
  input  logic [DATA_W-1:0]          mem_read_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REQ-1:0]         rd_valid
);

  localparam int                 IDX_W      = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ZERO_VEC   = {NUM_REQ{1'b0}};
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]         BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_e         state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] rd_valid_r;
  logic [IDX_W-1:0]   last_owner_r;
  logic [7:0]         burst_r;

  logic               pick_valid_s;
  logic [IDX_W-1:0]   pick_winner_s;
  logic               accept_s;
  logic               owner_req_s;
  logic               others_req_s;
  logic [NUM_REQ-1:0] rd_sel_s;

  sha256_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner_r),
    .valid      (pick_valid_s),
    .winner     (pick_winner_s)
  );

  // gnt_r is one-hot-or-zero, so masking with it isolates the owner's signals.
  assign accept_s     = |(gnt_r & acc);
  assign owner_req_s  = |(gnt_r & req);
  assign others_req_s = |(req & ~gnt_r);
  assign rd_sel_s     = gnt_r & acc & ~we_in;

  assign gnt      = gnt_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = mem_read_data;

  // Route the owner's accepted access to the memory port; idle port drives zeros.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = {ADDR_W{1'b0}};
    mem_write_data = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_r[k] && acc[k]) begin
        mem_we         = we_in[k];
        mem_addr       = addr_in[k*ADDR_W +: ADDR_W];
        mem_write_data = wdata_in[k*DATA_W +: DATA_W];
      end else begin
        mem_we         = mem_we;
      end
    end
  end

  // Ownership FSM, burst counting and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      gnt_r        <= ZERO_VEC;
      rd_valid_r   <= ZERO_VEC;
      last_owner_r <= LAST_RST;
      burst_r      <= 8'd0;
    end else begin
      rd_valid_r <= rd_sel_s;
      case (state_r)
        ST_OWN: begin
          if (!owner_req_s) begin
            gnt_r   <= ZERO_VEC;
            burst_r <= 8'd0;
            state_r <= ST_HANDOVER;
          end else if (accept_s && (burst_r == BURST_LAST)) begin
            burst_r <= 8'd0;
            if (others_req_s) begin
              gnt_r   <= ZERO_VEC;
              state_r <= ST_HANDOVER;
            end
          end else if (accept_s) begin
            burst_r <= burst_r + 8'd1;
          end
        end
        // HANDOVER is the single no-owner turnaround cycle; it arbitrates exactly like IDLE.
        ST_IDLE, ST_HANDOVER: begin
          if (pick_valid_s) begin
            gnt_r        <= ONE_HOT0 << pick_winner_s;
            last_owner_r <= pick_winner_s;
            burst_r      <= 8'd0;
            state_r      <= ST_OWN;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          gnt_r   <= ZERO_VEC;
          burst_r <= 8'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed plus randomized bench for sha256_mem_arbiter against an owner/queue-level reference model.
module tb_sha256_mem_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req, acc, we_in;
  logic [63:0]   addr_in;
  logic [127:0]  wdata_in;
  logic [3:0]    gnt, rd_valid;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_write_data, mem_read_data, rd_data;

  logic [31:0]   mem  [256];
  logic [31:0]   mmem [256];

  int checks = 0;
  int errors = 0;

  int            m_owner, m_cnt, m_last, m_rdv;
  logic [31:0]   m_rdd;

  sha256_mem_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .acc            (acc),
    .we_in          (we_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .gnt            (gnt),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[7:0]];
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5000000 + 32'(i) * 32'h00010101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0]  eg;
    logic        ew;
    logic [15:0] ea;
    logic [31:0] ed;
    logic [1:0]  o;
    o  = 2'(m_owner);
    eg = (m_owner >= 0) ? (4'b0001 << o) : 4'b0000;
    ew = 1'b0; ea = 16'h0000; ed = 32'h0;
    if (m_owner >= 0 && acc[o]) begin
      ew = we_in[o];
      ea = 16'(addr_in >> (16 * m_owner));
      ed = 32'(wdata_in >> (32 * m_owner));
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("rd_valid", 32'(rd_valid), (m_rdv >= 0) ? (32'd1 << m_rdv) : 32'd0);
    if (m_rdv >= 0) chk("rd_data", rd_data, m_rdd);
    chk("mem_we", 32'(mem_we), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_write_data", mem_write_data, ed);
  endtask

  // Reference: owner index (-1 = nobody), accesses used in this tenure, round-robin pointer.
  task automatic model_edge();
    logic [1:0]  o;
    logic [7:0]  a;
    bit          accepted;
    int          nxt_rdv;
    logic [31:0] nxt_rdd;
    int          w;
    o        = 2'(m_owner);
    accepted = (m_owner >= 0) && acc[o];
    nxt_rdv  = -1;
    nxt_rdd  = 32'h0;
    if (accepted) begin
      a = 8'(addr_in >> (16 * m_owner));
      if (we_in[o]) mmem[a] = 32'(wdata_in >> (32 * m_owner));
      else begin
        nxt_rdv = m_owner;
        nxt_rdd = mmem[a];
      end
    end
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_last = NUM_REQ - 1; m_rdv = -1;
      return;
    end
    m_rdv = nxt_rdv;
    m_rdd = nxt_rdd;
    if (m_owner >= 0) begin
      if (!req[o]) m_owner = -1;
      else if (accepted) begin
        m_cnt++;
        if (m_cnt == MAX_BURST) begin
          m_cnt = 0;
          if ((req & ~(4'b0001 << o)) != 4'b0000) m_owner = -1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w = (m_last + k) % NUM_REQ;
        if (req[w[1:0]]) begin
          m_owner = w; m_last = w; m_cnt = 0;
          break;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_port(input int k, input logic [15:0] a, input logic [31:0] d);
    addr_in[k*16 +: 16]  = a;
    wdata_in[k*32 +: 32] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = init_word(i);
      mmem[i] = init_word(i);
    end
    mem[8'h10]  = 32'hDEADBEEF;
    mmem[8'h10] = 32'hDEADBEEF;
    reset = 1'b1; req = 4'b0000; acc = 4'b0000; we_in = 4'b0000;
    addr_in = 64'h0; wdata_in = 128'h0;
    @(posedge clk);
    @(negedge clk);
    m_owner = -1; m_cnt = 0; m_last = NUM_REQ - 1; m_rdv = -1; m_rdd = 32'h0;

    // Reset state
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    reset = 1'b0;

    // Requester 1 wins first after reset, hand-over to requester 3
    req = 4'b1010; step();
    chk("r036_first_gnt", 32'(gnt), 32'h2);
    req = 4'b1000; step();
    chk("r036_handover_gnt", 32'(gnt), 32'h0);
    step();
    chk("r036_next_gnt", 32'(gnt), 32'h8);
    req = 4'b0000; step(); step();

    // Read by requester 2 returns memory data
    req = 4'b0100; step();
    chk("r037_gnt", 32'(gnt), 32'h4);
    acc = 4'b0100; we_in = 4'b0000; set_port(2, 16'h0010, 32'h0);
    step();
    acc = 4'b0000;
    chk("r037_rd_valid", 32'(rd_valid), 32'h4);
    chk("r037_rd_data", rd_data, 32'hDEADBEEF);
    req = 4'b0000; step(); step();

    // Burst limit forces release to waiting requester 3
    req = 4'b0001; step();
    chk("r038_gnt0", 32'(gnt), 32'h1);
    req = 4'b1001; acc = 4'b0001; we_in = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      set_port(0, 16'(8'h40 + i), 32'h0B000000 + 32'(i));
      step();
      chk("r038_burst_gnt", 32'(gnt), (i < 7) ? 32'h1 : 32'h0);
    end
    acc = 4'b0000; step();
    chk("r038_gnt3", 32'(gnt), 32'h8);
    req = 4'b0000; step(); step();

    // Lone requester keeps ownership through 20 writes
    req = 4'b0001; step();
    acc = 4'b0001; we_in = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      set_port(0, 16'(8'h20 + i), 32'h77000000 + 32'(i));
      step();
      chk("r039_gnt_held", 32'(gnt), 32'h1);
    end
    chk("r039_last_write", mem[8'h33], 32'h77000013);
    acc = 4'b0000; req = 4'b0000; step(); step();

    // Non-granted access never reaches memory
    req = 4'b1000; step();
    chk("r040_gnt", 32'(gnt), 32'h8);
    acc = 4'b1010; we_in = 4'b1010;
    set_port(1, 16'h0055, 32'hCAFEF00D);
    set_port(3, 16'h0066, 32'h12345678);
    #1;
    chk("r040_mem_addr", 32'(mem_addr), 32'h66);
    step();
    chk("r040_untouched", mem[8'h55], init_word(8'h55));
    chk("r040_written", mem[8'h66], 32'h12345678);
    acc = 4'b0000; we_in = 4'b0000; req = 4'b0000; step(); step();

    // Reset during ownership withdraws grant and pending read-valid
    req = 4'b0100; step();
    acc = 4'b0100; we_in = 4'b0000; set_port(2, 16'h0010, 32'h0);
    reset = 1'b1; step();
    chk("r041_gnt", 32'(gnt), 32'h0);
    chk("r041_rd_valid", 32'(rd_valid), 32'h0);
    reset = 1'b0; acc = 4'b0000; req = 4'b1111; step();
    chk("r041_post_gnt", 32'(gnt), 32'h1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      acc   = 4'($urandom);
      we_in = 4'($urandom);
      for (int k = 0; k < 4; k++) set_port(k, 16'($urandom_range(0, 255)), $urandom);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; req = 4'b0000; acc = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
